fetch_controller: RTL

//   Sequences instruction fetch from the combinational-read instruction memory
//   (10-bit address, 16-bit word). Owns the program counter (PC) and presents one

---
 rtl/fetch_controller.sv | 109 ++++++++++
 1 files changed

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, reads a combinational instruction memory
// and hands one registered instruction to decode over valid/ready. Optional HALT
// detection is enabled by defining FETCH_HALT_DETECT_EN.
module fetch_controller #(
  parameter int                   ADDR_W    = 10,
  parameter int                   INSTR_W   = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]   HALT_WORD = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               busy,
  output logic               halted,
  output logic [15:0]        fetch_count
);

`ifdef FETCH_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t               r_state;
  logic [ADDR_W-1:0]    r_pc;
  logic [ADDR_W-1:0]    r_out_pc;
  logic [INSTR_W-1:0]   r_out_instr;
  logic                 r_out_valid;
  logic [15:0]          r_count;

  logic w_accept;
  logic w_redirect;
  logic w_capture;
  logic w_halt_hit;

  assign w_accept   = r_out_valid && out_ready;
  // Redirect outranks both capture and backpressure, but is meaningless before start.
  assign w_redirect = redirect_valid && (r_state != S_IDLE);
  assign w_capture  = (r_state == S_FETCH) && (!r_out_valid || out_ready) && !redirect_valid;
  assign w_halt_hit = HALT_EN && (imem_instr == HALT_WORD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_out_pc    <= '0;
      r_out_instr <= '0;
      r_out_valid <= 1'b0;
      r_count     <= '0;
    end else begin
      if (w_accept && (r_count != 16'hFFFF))
        r_count <= r_count + 16'd1;

      if (w_redirect) begin
        r_pc        <= redirect_pc;
        r_out_valid <= 1'b0;
        r_state     <= S_FETCH;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start)
              r_state <= S_FETCH;
            if (w_accept)
              r_out_valid <= 1'b0;
          end
          S_FETCH: begin
            if (w_capture) begin
              r_out_instr <= imem_instr;
              r_out_pc    <= r_pc;
              r_out_valid <= 1'b1;
              // A HALT word is delivered but the PC parks on it until redirected.
              if (w_halt_hit)
                r_state <= S_HALTED;
              else
                r_pc <= r_pc + ADDR_W'(1);
            end
          end
          default: begin
            if (w_accept)
              r_out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign imem_addr   = r_pc;
  assign out_valid   = r_out_valid;
  assign out_instr   = r_out_instr;
  assign out_pc      = r_out_pc;
  assign fetch_count = r_count;
  assign busy        = (r_state == S_FETCH);
  assign halted      = HALT_EN && (r_state == S_HALTED);

endmodule
